// File: rtl/npu_pkg.sv
// Shared constants for the NPU core datapath.
//   NUM_COLS/PSUM_BW : PSUM row geometry from pe_array
//   OUT_BW           : quantized output byte width
//   MULT_BW/SHIFT_BW : requant multiplier / shift widths
//   ADDR_OUT         : output byte address width (HWC)
//   SAT_MAX/SAT_MIN  : signed 8-bit saturation bounds
//   ctrl_state_t     : drain controller FSM encoding
package npu_pkg;

  localparam int unsigned NUM_COLS = 32;
  localparam int unsigned PSUM_BW  = 32;
  localparam int unsigned OUT_BW   = 8;
  localparam int unsigned MULT_BW  = 16;
  localparam int unsigned SHIFT_BW = 5;
  localparam int unsigned ADDR_OUT = 16;

  // Product of signed PSUM and zero-extended multiplier fits exactly in 48 bits;
  // two guard bits absorb the rounding add and the zero-point add.
  localparam int unsigned PROD_BW = PSUM_BW + MULT_BW;
  localparam int unsigned ACC_BW  = PROD_BW + 2;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROW,
    SERIAL,
    FLUSH,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/psum_out_ctrlr_requant_pipe.sv
// requant_pipe: 3-stage PSUM -> int8 requantization with valid/stall.
//   S1: p = psum * mult (signed x unsigned, 48-bit)
//   S2: rounding arithmetic shift, optional ReLU, zero-point add
//   S3: saturate to [-128,127] into the output register
// Ports:
//   clk, resetn (sync, active-high)
//   in_valid/in_ready, in_psum, in_addr, in_last : issue side
//   mult, shift, zp, relu_en                     : requant config (held stable)
//   out_valid/out_ready, out_data, out_addr, out_last : byte side
//   drained : no work upstream of the output register and the output
//             register is empty or handing off this cycle
module requant_pipe
  import npu_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PSUM_BW-1:0]  in_psum,
  input  logic [ADDR_OUT-1:0] in_addr,
  input  logic                in_last,
  input  logic [MULT_BW-1:0]  mult,
  input  logic [SHIFT_BW-1:0] shift,
  input  logic [OUT_BW-1:0]   zp,
  input  logic                relu_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BW-1:0]   out_data,
  output logic [ADDR_OUT-1:0] out_addr,
  output logic                out_last,
  output logic                drained
);

  localparam logic signed [ACC_BW-1:0] SAT_HI = ACC_BW'(SAT_MAX);
  localparam logic signed [ACC_BW-1:0] SAT_LO = ACC_BW'(SAT_MIN);

  logic                       s1_v, s2_v;
  logic signed [PROD_BW-1:0]  s1_p;
  logic signed [ACC_BW-1:0]   s2_r;
  logic [ADDR_OUT-1:0]        s1_a, s2_a;
  logic                       s1_l, s2_l;

  logic adv1, adv2, adv3;
  assign adv3     = !out_valid || out_ready;
  assign adv2     = !s2_v || adv3;
  assign adv1     = !s1_v || adv2;
  assign in_ready = adv1;
  assign drained  = !s1_v && !s2_v && adv3;

  logic signed [PROD_BW-1:0] prod_c;
  logic signed [ACC_BW-1:0]  p_ext, rnd, sum, shifted, relu_v, zp_ext, r_c;
  logic [OUT_BW-1:0]         sat_c;

  always_comb begin
    prod_c  = $signed({{MULT_BW{in_psum[PSUM_BW-1]}}, in_psum}) *
              $signed({{PSUM_BW{1'b0}}, mult});
    p_ext   = $signed({{(ACC_BW-PROD_BW){s1_p[PROD_BW-1]}}, s1_p});
    // Half-LSB rounding term; zero when no shift is requested so r = p.
    rnd     = (shift == '0) ? '0 : (ACC_BW'(1) <<< (shift - SHIFT_BW'(1)));
    sum     = p_ext + rnd;
    shifted = sum >>> shift;
    relu_v  = (relu_en && shifted[ACC_BW-1]) ? '0 : shifted;
    zp_ext  = $signed({{(ACC_BW-OUT_BW){zp[OUT_BW-1]}}, zp});
    r_c     = relu_v + zp_ext;
    if (s2_r > SAT_HI)      sat_c = OUT_BW'(SAT_MAX);
    else if (s2_r < SAT_LO) sat_c = OUT_BW'(SAT_MIN);
    else                    sat_c = s2_r[OUT_BW-1:0];
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      s1_v      <= 1'b0;
      s1_p      <= '0;
      s1_a      <= '0;
      s1_l      <= 1'b0;
      s2_v      <= 1'b0;
      s2_r      <= '0;
      s2_a      <= '0;
      s2_l      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (adv1) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_p <= prod_c;
          s1_a <= in_addr;
          s1_l <= in_last;
        end
      end
      if (adv2) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_r <= r_c;
          s2_a <= s1_a;
          s2_l <= s1_l;
        end
      end
      if (adv3) begin
        out_valid <= s2_v;
        if (s2_v) begin
          out_data <= sat_c;
          out_addr <= s2_a;
          out_last <= s2_l;
        end
      end
    end
  end

endmodule

// File: rtl/psum_out_ctrlr.sv
// psum_out_ctrlr: drain side of the core. Accepts one 32-lane PSUM row per
// handshake (oc outer, h inner), requantizes lanes 0..IMG_W-1 to int8 and
// streams them out with HWC byte addresses (h*IMG_W + w)*OC + oc.
// Ports:
//   clk, resetn (sync, active-high), start (config latch pulse)
//   OC, IMG_H, IMG_W, quant_mult, quant_shift, quant_zp, relu_en : tile config
//   psum_valid/psum_ready, psum_rows : PSUM row input
//   out_valid/out_ready, out_data, out_addr, out_last : byte stream
//   busy : start..done, done : one-cycle completion pulse
module psum_out_ctrlr
  import npu_pkg::*;
(
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic [7:0]                  OC,
  input  logic [5:0]                  IMG_H,
  input  logic [5:0]                  IMG_W,
  input  logic [MULT_BW-1:0]          quant_mult,
  input  logic [SHIFT_BW-1:0]         quant_shift,
  input  logic [OUT_BW-1:0]           quant_zp,
  input  logic                        relu_en,
  input  logic                        psum_valid,
  output logic                        psum_ready,
  input  logic [NUM_COLS*PSUM_BW-1:0] psum_rows,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_BW-1:0]           out_data,
  output logic [ADDR_OUT-1:0]         out_addr,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned LANE_BW = $clog2(NUM_COLS);

  ctrl_state_t         state;
  logic [7:0]          cfg_oc;
  logic [5:0]          cfg_h, cfg_w;
  logic [MULT_BW-1:0]  cfg_mult;
  logic [SHIFT_BW-1:0] cfg_shift;
  logic [OUT_BW-1:0]   cfg_zp;
  logic                cfg_relu;

  logic [7:0]          oc_cnt;
  logic [5:0]          h_cnt;
  logic [LANE_BW-1:0]  lane;
  logic [PSUM_BW-1:0]  hold [NUM_COLS];

  logic                issue_valid, issue_ready, issue_fire;
  logic                last_lane, last_h, last_oc;
  logic [ADDR_OUT-1:0] issue_addr;
  logic                drained;

  always_comb begin
    issue_valid = (state == SERIAL);
    issue_fire  = issue_valid && issue_ready;
    last_lane   = (6'(lane) == cfg_w - 6'd1);
    last_h      = (h_cnt == cfg_h - 6'd1);
    last_oc     = (oc_cnt == cfg_oc - 8'd1);
    issue_addr  = (ADDR_OUT'(h_cnt) * ADDR_OUT'(cfg_w) + ADDR_OUT'(lane)) * ADDR_OUT'(cfg_oc)
                  + ADDR_OUT'(oc_cnt);
  end

  requant_pipe u_requant (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (issue_valid),
    .in_ready  (issue_ready),
    .in_psum   (hold[lane]),
    .in_addr   (issue_addr),
    .in_last   (last_lane && last_h && last_oc),
    .mult      (cfg_mult),
    .shift     (cfg_shift),
    .zp        (cfg_zp),
    .relu_en   (cfg_relu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .drained   (drained)
  );

  always_ff @(posedge clk) begin
    if (resetn) begin
      state      <= IDLE;
      psum_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_oc     <= '0;
      cfg_h      <= '0;
      cfg_w      <= '0;
      cfg_mult   <= '0;
      cfg_shift  <= '0;
      cfg_zp     <= '0;
      cfg_relu   <= 1'b0;
      oc_cnt     <= '0;
      h_cnt      <= '0;
      lane       <= '0;
      for (int unsigned i = 0; i < NUM_COLS; i++) hold[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cfg_oc    <= OC;
            cfg_h     <= IMG_H;
            cfg_w     <= IMG_W;
            cfg_mult  <= quant_mult;
            cfg_shift <= quant_shift;
            cfg_zp    <= quant_zp;
            cfg_relu  <= relu_en;
            oc_cnt    <= '0;
            h_cnt     <= '0;
            lane      <= '0;
            busy      <= 1'b1;
            if (OC == '0 || IMG_H == '0 || IMG_W == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= WAIT_ROW;
              psum_ready <= 1'b1;
            end
          end
        end
        WAIT_ROW: begin
          if (psum_valid && psum_ready) begin
            for (int unsigned i = 0; i < NUM_COLS; i++)
              hold[i] <= psum_rows[i*PSUM_BW +: PSUM_BW];
            lane       <= '0;
            psum_ready <= 1'b0;
            state      <= SERIAL;
          end
        end
        SERIAL: begin
          if (issue_fire) begin
            if (last_lane) begin
              lane <= '0;
              if (last_h) begin
                h_cnt <= '0;
                if (last_oc) begin
                  state <= FLUSH;
                end else begin
                  oc_cnt     <= oc_cnt + 8'd1;
                  state      <= WAIT_ROW;
                  psum_ready <= 1'b1;
                end
              end else begin
                h_cnt      <= h_cnt + 6'd1;
                state      <= WAIT_ROW;
                psum_ready <= 1'b1;
              end
            end else begin
              lane <= lane + LANE_BW'(1);
            end
          end
        end
        FLUSH: begin
          // drained includes the final byte handing off this cycle, so done
          // follows directly behind the last byte.
          if (drained) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_out_ctrlr.sv
module tb_psum_out_ctrlr;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    OC = '0;
  logic [5:0]    IMG_H = '0, IMG_W = '0;
  logic [15:0]   quant_mult = '0;
  logic [4:0]    quant_shift = '0;
  logic [7:0]    quant_zp = '0;
  logic          relu_en = 1'b0;
  logic          psum_valid = 1'b0;
  logic          psum_ready;
  logic [1023:0] psum_rows = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_data;
  logic [15:0]   out_addr;
  logic          out_last;
  logic          busy, done;

  psum_out_ctrlr dut (
    .clk(clk), .resetn(resetn), .start(start), .OC(OC), .IMG_H(IMG_H), .IMG_W(IMG_W),
    .quant_mult(quant_mult), .quant_shift(quant_shift), .quant_zp(quant_zp), .relu_en(relu_en),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_rows(psum_rows),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic [15:0] a; logic l; } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;
  int cyc = 0;
  int c_oc, c_h, c_w, c_mult, c_shift, c_zp;
  bit c_relu;
  int lanes_in [32];
  int hs_cyc = 0, start_cyc = 0, first_valid_cyc = -1;
  int done_cnt = 0, done_cyc = -1, byte_cnt = 0, last_acc_cyc = -2;
  bit bp_en = 0, ready_seen = 0, stalled = 0;
  logic [7:0]  st_data;
  logic [15:0] st_addr;

  task automatic check(string tag, longint got, longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(int psum, int mult, int shift, int zp, bit relu);
    longint p;
    p = longint'(psum) * longint'(mult);
    if (shift > 0) p = (p + (longint'(1) <<< (shift - 1))) >>> shift;
    if (relu && p < 0) p = 0;
    p = p + zp;
    if (p > 127) p = 127;
    if (p < -128) p = -128;
    return p[7:0];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: picks out_ready for the coming edge, then scores the byte.
  initial forever begin
    @(negedge clk);
    if (resetn) begin
      out_ready = 1'b1;
      stalled = 0;
    end else begin
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, st_data);
        check("stall_addr", out_addr, st_addr);
      end
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (psum_ready) ready_seen = 1;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        stalled = 0;
        byte_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_byte", out_addr, -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("data", out_data, e.d);
          check("addr", out_addr, e.a);
          check("last", out_last, e.l);
        end
        if (out_last) last_acc_cyc = cyc + 1;
      end else if (out_valid) begin
        stalled = 1;
        st_data = out_data;
        st_addr = out_addr;
      end else begin
        stalled = 0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_tile(int oc, int h, int w, int mult, int shift, int zp, bit relu);
    @(negedge clk);
    OC = 8'(oc); IMG_H = 6'(h); IMG_W = 6'(w);
    quant_mult = 16'(mult); quant_shift = 5'(shift); quant_zp = 8'(zp); relu_en = relu;
    c_oc = oc; c_h = h; c_w = w; c_mult = mult; c_shift = shift; c_zp = zp; c_relu = relu;
    first_valid_cyc = -1;
    start = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic send_row(int o, int h);
    int n;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 32; i++)
      psum_rows[i*32 +: 32] = (i < c_w) ? lanes_in[i] : $urandom;
    psum_valid = 1'b1;
    n = 0;
    while (!psum_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!psum_ready) begin
      check("row_accept", 0, 1);
      psum_valid = 1'b0;
      return;
    end
    for (int w = 0; w < c_w; w++) begin
      e.d = model(lanes_in[w], c_mult, c_shift, c_zp, c_relu);
      e.a = 16'((h * c_w + w) * c_oc + o);
      e.l = (o == c_oc - 1) && (h == c_h - 1) && (w == c_w - 1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1 hs_cyc = cyc;
    psum_valid = 1'b0;
    @(negedge clk);
    check("ready_serial", psum_ready, 0);
  endtask

  task automatic run_tile(int oc, int h, int w, int mult, int shift, int zp, bit relu,
                          bit rnd, bit poke);
    int d0, b0, n;
    d0 = done_cnt;
    b0 = byte_cnt;
    start_tile(oc, h, w, mult, shift, zp, relu);
    for (int o = 0; o < oc; o++)
      for (int hh = 0; hh < h; hh++) begin
        if (rnd) for (int i = 0; i < 32; i++) lanes_in[i] = $urandom;
        send_row(o, hh);
        if (poke && o == 0 && hh == 0) begin
          // start while busy must be ignored; zero width would end the tile
          @(negedge clk);
          IMG_W = 6'd0;
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    n = 0;
    while (done_cnt == d0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done_cnt - d0, 1);
    check("done_timing", done_cyc, last_acc_cyc);
    check("byte_count", byte_cnt - b0, oc * h * w);
    check("sb_empty", sb.size(), 0);
    @(negedge clk);
    check("busy_clear", busy, 0);
  endtask

  initial begin
    int d0, b0;
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, b0;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_psum_ready", psum_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
    resetn = 1'b0;

    // 1: identity quant, saturation at both ends, latency
    lanes_in[0] = 5; lanes_in[1] = -3; lanes_in[2] = 200; lanes_in[3] = -200;
    run_tile(1, 1, 4, 1, 0, 0, 0, 0, 0);
    check("latency", first_valid_cyc, hs_cyc + 3);

    // 2: rounding shift, ReLU, zero point -> 15, 10, 11
    lanes_in[0] = 7; lanes_in[1] = -7; lanes_in[2] = 1;
    run_tile(1, 1, 3, 3, 2, 10, 1, 0, 0);

    // 3: multi-row HWC addressing, with an ignored start mid-tile
    run_tile(2, 2, 2, 1, 0, 0, 0, 1, 1);

    // 4: same tile under random backpressure
    bp_en = 1;
    run_tile(2, 2, 2, 1, 0, 0, 0, 1, 0);

    // 7: full-width rows, random quant, backpressure
    run_tile(1, 2, 32, int'($urandom_range(0, 65535)), int'($urandom_range(0, 20)),
             int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)), 1, 0);
    run_tile(3, 1, 5, 40000, 31, -7, 0, 1, 0);
    bp_en = 0;

    // 5: zero-sized tiles
    for (int k = 0; k < 2; k++) begin
      d0 = done_cnt;
      b0 = byte_cnt;
      ready_seen = 0;
      if (k == 0) start_tile(1, 1, 0, 1, 0, 0, 0);
      else        start_tile(0, 4, 4, 1, 0, 0, 0);
      repeat (4) @(negedge clk);
      check("zero_done_cnt", done_cnt - d0, 1);
      check("zero_done_cyc", done_cyc, start_cyc);
      check("zero_ready", ready_seen, 0);
      check("zero_bytes", byte_cnt - b0, 0);
      check("zero_busy", busy, 0);
    end

    // 6: reset mid-tile, then a fresh tile
    d0 = done_cnt;
    start_tile(2, 2, 2, 1, 0, 0, 0);
    for (int i = 0; i < 32; i++) lanes_in[i] = $urandom;
    send_row(0, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_psum_ready", psum_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_addr", out_addr, 0);
    resetn = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", done_cnt - d0, 0);
    run_tile(2, 2, 2, 2, 1, -3, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
